// File: rtl/snitch_pkg.sv
// snitch_pkg
//   Shared types for the accelerator offload arbiter: the accelerator
//   request/response structs, arbiter sizing constants and the port-index
//   type used in the grant-order FIFO.
//   No ports (package).
package snitch_pkg;

    localparam int AccArbNrPorts    = 4;
    localparam int AccArbOrderDepth = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  id;
        logic [31:0] data_op;
        logic [63:0] data_arga;
        logic [63:0] data_argb;
        logic [63:0] data_argc;
    } acc_req_t;

    typedef struct packed {
        logic [4:0]  id;
        logic        error;
        logic [63:0] data;
    } acc_resp_t;

    // Width of an index into n ports; a single port still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(AccArbNrPorts)-1:0] acc_arb_idx_t;

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3
//   Small synchronous FIFO used to remember the order in which ports were
//   granted. A push while full and a pop while empty are ignored.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     push, data_in      write side
//     pop, data_out      read side (data_out shows the head entry)
//     full, empty        occupancy flags
module fifo_v3 #(
    parameter int Depth = 8,
    parameter int Width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] data_in,
    input  logic             pop,
    output logic [Width-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_q;
    logic [AddrW-1:0] rd_q;
    logic [AddrW:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt_q == (AddrW+1)'(Depth));
    assign empty    = (cnt_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == AddrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == AddrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_in;
    end

endmodule

// File: rtl/snitch_acc_offload_arbiter.sv
// snitch_acc_offload_arbiter
//   Shares one accelerator among NrPorts cores. Requests are arbitrated
//   round-robin onto a single downstream port; the granted port index is
//   queued so the in-order responses can be routed back to their issuers.
//   Per-port credits limit how many requests each core may have in flight.
//   Ports:
//     clk_i, rst_i                         clock, asynchronous active-high reset
//     req_i/req_valid_i/req_ready_o        per-core request channels
//     resp_o/resp_valid_o/resp_ready_i     per-core response channels
//     acc_req_o/_valid_o/_ready_i          request to the shared unit
//     acc_resp_i/_valid_i/acc_resp_ready_o response from the shared unit
//   Build option: SNITCH_ACC_ARB_RESP_SPILL_EN inserts a two-slot spill
//   register on the response path (one cycle of latency, full throughput).
//   Handshakes: a transfer happens on every rising edge where valid and
//   ready are both high; a valid source keeps its payload until then.
module snitch_acc_offload_arbiter
    import snitch_pkg::*;
#(
    parameter int NrPorts        = AccArbNrPorts,
    parameter int MaxOutstanding = 4,
    parameter int OrderDepth     = AccArbOrderDepth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  acc_req_t  [NrPorts-1:0]  req_i,
    input  logic      [NrPorts-1:0]  req_valid_i,
    output logic      [NrPorts-1:0]  req_ready_o,
    output acc_resp_t [NrPorts-1:0]  resp_o,
    output logic      [NrPorts-1:0]  resp_valid_o,
    input  logic      [NrPorts-1:0]  resp_ready_i,
    output acc_req_t                 acc_req_o,
    output logic                     acc_req_valid_o,
    input  logic                     acc_req_ready_i,
    input  acc_resp_t                acc_resp_i,
    input  logic                     acc_resp_valid_i,
    output logic                     acc_resp_ready_o
);

    localparam int IdxW = idx_width(NrPorts);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    typedef logic [IdxW-1:0] idx_t;

    idx_t               rr_q;
    idx_t               lock_idx_q;
    logic               locked_q;
    logic [CntW-1:0]    credit_q [NrPorts];
    logic [NrPorts-1:0] eligible;
    logic [NrPorts-1:0] credit_inc;
    logic [NrPorts-1:0] credit_dec;
    idx_t               grant_rr;
    logic               grant_found;
    idx_t               grant;
    idx_t               head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    int                 p;

    // ---------------- request side ----------------
    always_comb begin
        eligible    = '0;
        grant_rr    = '0;
        grant_found = 1'b0;
        p           = 0;
        for (int q = 0; q < NrPorts; q++) begin
            eligible[q] = req_valid_i[q] && (credit_q[q] < MaxCnt) && !fifo_full;
        end
        for (int i = 0; i < NrPorts; i++) begin
            p = (int'(rr_q) + i) % NrPorts;
            if (!grant_found && eligible[p]) begin
                grant_found = 1'b1;
                grant_rr    = idx_t'(p);
            end
        end
        // A stalled offer stays with its port until it is accepted.
        grant           = locked_q ? lock_idx_q : grant_rr;
        acc_req_valid_o = !rst_i && (locked_q || grant_found);
        acc_req_o       = req_i[grant];
        push            = acc_req_valid_o && acc_req_ready_i;
        req_ready_o     = '0;
        if (push) req_ready_o[grant] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (push) begin
                rr_q     <= (grant == idx_t'(NrPorts - 1)) ? '0 : grant + 1'b1;
                locked_q <= 1'b0;
            end else if (acc_req_valid_o) begin
                locked_q   <= 1'b1;
                lock_idx_q <= grant;
            end
        end
    end

    // ---------------- response side ----------------
`ifdef SNITCH_ACC_ARB_RESP_SPILL_EN
    logic      out_valid_q;
    acc_resp_t out_data_q;
    idx_t      out_idx_q;
    logic      sp_valid_q;
    acc_resp_t sp_data_q;
    idx_t      sp_idx_q;
    logic      out_fire;

    always_comb begin
        acc_resp_ready_o = !rst_i && !sp_valid_q;
        pop              = acc_resp_valid_i && acc_resp_ready_o && !fifo_empty;
        out_fire         = out_valid_q && resp_ready_i[out_idx_q];
        resp_o           = {NrPorts{out_data_q}};
        resp_valid_o     = '0;
        if (!rst_i) resp_valid_o[out_idx_q] = out_valid_q;
    end

    // Output slot plus a side slot that catches the beat arriving while the
    // output is stalled, so the upstream ready never depends on resp_ready_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            sp_valid_q  <= 1'b0;
            sp_data_q   <= '0;
            sp_idx_q    <= '0;
        end else if (out_fire || !out_valid_q) begin
            if (sp_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sp_data_q;
                out_idx_q   <= sp_idx_q;
                sp_valid_q  <= 1'b0;
            end else begin
                out_valid_q <= pop;
                out_data_q  <= acc_resp_i;
                out_idx_q   <= head;
            end
        end else if (pop) begin
            sp_valid_q <= 1'b1;
            sp_data_q  <= acc_resp_i;
            sp_idx_q   <= head;
        end
    end
`else
    always_comb begin
        resp_o       = {NrPorts{acc_resp_i}};
        resp_valid_o = '0;
        if (!rst_i && !fifo_empty) resp_valid_o[head] = acc_resp_valid_i;
        // With nothing outstanding a stray response is swallowed.
        if (rst_i)           acc_resp_ready_o = 1'b0;
        else if (fifo_empty) acc_resp_ready_o = acc_resp_valid_i;
        else                 acc_resp_ready_o = resp_ready_i[head];
        pop = acc_resp_valid_i && acc_resp_ready_o && !fifo_empty;
    end
`endif

    fifo_v3 #(
        .Depth (OrderDepth),
        .Width (IdxW)
    ) i_order_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .data_in  (grant),
        .pop      (pop),
        .data_out (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ---------------- credits ----------------
    always_comb begin
        credit_inc = '0;
        credit_dec = '0;
        for (int q = 0; q < NrPorts; q++) begin
            credit_inc[q] = push && (grant == idx_t'(q));
            credit_dec[q] = pop && (head == idx_t'(q));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int q = 0; q < NrPorts; q++) credit_q[q] <= '0;
        end else begin
            for (int q = 0; q < NrPorts; q++) begin
                if (credit_inc[q] && !credit_dec[q])      credit_q[q] <= credit_q[q] + 1'b1;
                else if (credit_dec[q] && !credit_inc[q]) credit_q[q] <= credit_q[q] - 1'b1;
            end
        end
    end

    // ---------------- protocol checks ----------------
    a_resp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(acc_resp_valid_i && fifo_empty));

    for (genvar g = 0; g < NrPorts; g++) begin : g_credit_chk
        a_credit_over: assert property (@(posedge clk_i) disable iff (rst_i)
            !(credit_inc[g] && !credit_dec[g] && credit_q[g] == MaxCnt));
        a_credit_under: assert property (@(posedge clk_i) disable iff (rst_i)
            !(credit_dec[g] && !credit_inc[g] && credit_q[g] == '0));
    end

endmodule

// File: tb/tb_snitch_acc_offload_arbiter.sv
// tb_snitch_acc_offload_arbiter
//   Directed, table-driven bench for the offload arbiter (default build).
//   Each vector drives one cycle of inputs on the falling edge and compares
//   the combinational outputs 1 time unit later; the rising edge in between
//   vectors advances the DUT state, so the table is one long scripted run.
module tb_snitch_acc_offload_arbiter;
    import snitch_pkg::*;

    logic            clk;
    logic            rst;
    acc_req_t  [3:0] req_i;
    logic      [3:0] req_valid_i;
    logic      [3:0] req_ready_o;
    acc_resp_t [3:0] resp_o;
    logic      [3:0] resp_valid_o;
    logic      [3:0] resp_ready_i;
    acc_req_t        acc_req_o;
    logic            acc_req_valid_o;
    logic            acc_req_ready_i;
    acc_resp_t       acc_resp_i;
    logic            acc_resp_valid_i;
    logic            acc_resp_ready_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] rv;     // req_valid_i
        logic       ar;     // acc_req_ready_i
        logic       av;     // acc_resp_valid_i
        logic [3:0] rr;     // resp_ready_i
        logic [3:0] e_rq;   // expected req_ready_o
        logic       e_av;   // expected acc_req_valid_o
        int         e_port; // port whose payload must be on acc_req_o
        logic [3:0] e_rsv;  // expected resp_valid_o
        logic       e_aro;  // expected acc_resp_ready_o
    } vec_t;

    vec_t vecs[$];
    vec_t post[$];

    snitch_acc_offload_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .resp_o           (resp_o),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .acc_req_o        (acc_req_o),
        .acc_req_valid_o  (acc_req_valid_o),
        .acc_req_ready_i  (acc_req_ready_i),
        .acc_resp_i       (acc_resp_i),
        .acc_resp_valid_i (acc_resp_valid_i),
        .acc_resp_ready_o (acc_resp_ready_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic ar, input logic av,
                                input logic [3:0] rr, input logic [3:0] e_rq, input logic e_av,
                                input int e_port, input logic [3:0] e_rsv, input logic e_aro);
        vec_t v;
        v.rv = rv; v.ar = ar; v.av = av; v.rr = rr;
        v.e_rq = e_rq; v.e_av = e_av; v.e_port = e_port; v.e_rsv = e_rsv; v.e_aro = e_aro;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int n);
        @(negedge clk);
        req_valid_i      = v.rv;
        acc_req_ready_i  = v.ar;
        acc_resp_valid_i = v.av;
        resp_ready_i     = v.rr;
        acc_resp_i.id    = 5'(n);
        acc_resp_i.error = 1'b0;
        acc_resp_i.data  = 64'hD000 + 64'(n);
        #1;
        chk($sformatf("%s%0d req_ready", tag, n), 64'(req_ready_o), 64'(v.e_rq));
        chk($sformatf("%s%0d acc_req_valid", tag, n), 64'(acc_req_valid_o), 64'(v.e_av));
        if (v.e_av)
            chk($sformatf("%s%0d acc_req_addr", tag, n), 64'(acc_req_o.addr), 64'(32'h1000 + v.e_port));
        chk($sformatf("%s%0d resp_valid", tag, n), 64'(resp_valid_o), 64'(v.e_rsv));
        chk($sformatf("%s%0d acc_resp_ready", tag, n), 64'(acc_resp_ready_o), 64'(v.e_aro));
        for (int q = 0; q < 4; q++) begin
            if (v.e_rsv[q])
                chk($sformatf("%s%0d resp_data_p%0d", tag, n, q), resp_o[q].data, 64'hD000 + 64'(n));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " req_ready"}, 64'(req_ready_o), 64'h0);
        chk({tag, " acc_req_valid"}, 64'(acc_req_valid_o), 64'h0);
        chk({tag, " resp_valid"}, 64'(resp_valid_o), 64'h0);
        chk({tag, " acc_resp_ready"}, 64'(acc_resp_ready_o), 64'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst              = 1'b1;
        req_valid_i      = '0;
        acc_req_ready_i  = 1'b0;
        acc_resp_valid_i = 1'b0;
        resp_ready_i     = '0;
        acc_resp_i       = '0;
        for (int q = 0; q < 4; q++) begin
            req_i[q]           = '0;
            req_i[q].addr      = 32'h1000 + 32'(q);
            req_i[q].id        = 5'(q);
            req_i[q].data_arga = 64'hA0 + 64'(q);
        end

        //            rv    ar    av    rr    e_rq  e_av port e_rsv e_aro
        // all ports valid, downstream ready: 0,1,2,3,0
        vecs.push_back(mk(4'hF, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF, 1'b1, 1'b0, 4'h0, 4'h4, 1'b1, 2, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF, 1'b1, 1'b0, 4'h0, 4'h8, 1'b1, 3, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 0, 4'h0, 1'b0));
        // drain in grant order
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h1, 1'b1));
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h2, 1'b1));
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h4, 1'b1));
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h8, 1'b1));
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h1, 1'b1));
        // grants 3,0,3 then responses routed 3,0,3
        vecs.push_back(mk(4'h8, 1'b1, 1'b0, 4'h0, 4'h8, 1'b1, 3, 4'h0, 1'b0));
        vecs.push_back(mk(4'h1, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 0, 4'h0, 1'b0));
        vecs.push_back(mk(4'h8, 1'b1, 1'b0, 4'h0, 4'h8, 1'b1, 3, 4'h0, 1'b0));
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h8, 1'b1));
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h1, 1'b1));
        vecs.push_back(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h8, 1'b1));
        // pointer at 0: port 2 stalled 3 cycles; port 0 must not preempt
        vecs.push_back(mk(4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2, 4'h0, 1'b0));
        vecs.push_back(mk(4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2, 4'h0, 1'b0));
        vecs.push_back(mk(4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2, 4'h0, 1'b0));
        vecs.push_back(mk(4'h5, 1'b1, 1'b0, 4'h0, 4'h4, 1'b1, 2, 4'h0, 1'b0));
        vecs.push_back(mk(4'h1, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 0, 4'h0, 1'b0));
        // head (port 2) back-pressures two cycles, then both drain
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, -1, 4'h4, 1'b0));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, -1, 4'h4, 1'b0));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 4'h4, 4'h0, 1'b0, -1, 4'h4, 1'b1));
        vecs.push_back(mk(4'h0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0, -1, 4'h1, 1'b1));
        // port 1 uses its 4 credits, 5th blocked, freed by one response
        vecs.push_back(mk(4'h2, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1, 4'h0, 1'b0));
        vecs.push_back(mk(4'h2, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1, 4'h0, 1'b0));
        vecs.push_back(mk(4'h2, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1, 4'h0, 1'b0));
        vecs.push_back(mk(4'h2, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1, 4'h0, 1'b0));
        vecs.push_back(mk(4'h2, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, -1, 4'h0, 1'b0));
        vecs.push_back(mk(4'h2, 1'b1, 1'b1, 4'h2, 4'h0, 1'b0, -1, 4'h2, 1'b1));
        vecs.push_back(mk(4'h2, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1, 4'h0, 1'b0));
        // fill the order FIFO to 8 with ports 2,3,0,2
        vecs.push_back(mk(4'hD, 1'b1, 1'b0, 4'h0, 4'h4, 1'b1, 2, 4'h0, 1'b0));
        vecs.push_back(mk(4'hD, 1'b1, 1'b0, 4'h0, 4'h8, 1'b1, 3, 4'h0, 1'b0));
        vecs.push_back(mk(4'hD, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hD, 1'b1, 1'b0, 4'h0, 4'h4, 1'b1, 2, 4'h0, 1'b0));
        // full: nothing eligible, even while a pop happens
        vecs.push_back(mk(4'hD, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, -1, 4'h0, 1'b0));
        vecs.push_back(mk(4'hD, 1'b1, 1'b1, 4'h2, 4'h0, 1'b0, -1, 4'h2, 1'b1));
        vecs.push_back(mk(4'hD, 1'b1, 1'b0, 4'h0, 4'h8, 1'b1, 3, 4'h0, 1'b0));

        // after mid-run reset: pointer 0, credits 0, FIFO empty
        post.push_back(mk(4'hF, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 0, 4'h0, 1'b0));
        post.push_back(mk(4'h2, 1'b1, 1'b0, 4'h0, 4'h2, 1'b1, 1, 4'h0, 1'b0));
        post.push_back(mk(4'h0, 1'b0, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h1, 1'b1));
        post.push_back(mk(4'h0, 1'b0, 1'b1, 4'hF, 4'h0, 1'b0, -1, 4'h2, 1'b1));

        // initial reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "v", i);

        // reset with 8 requests in flight, all inputs active
        @(negedge clk);
        rst              = 1'b1;
        req_valid_i      = 4'hF;
        acc_req_ready_i  = 1'b1;
        acc_resp_valid_i = 1'b1;
        resp_ready_i     = 4'hF;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        #1;
        check_all_zero("midrst_edge");
        req_valid_i      = '0;
        acc_req_ready_i  = 1'b0;
        acc_resp_valid_i = 1'b0;
        resp_ready_i     = '0;
        rst              = 1'b0;

        for (int i = 0; i < post.size(); i++) apply(post[i], "p", i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
